// File: rtl/spi_io_expander_pkg.sv
`default_nettype none
// ==========================================================================
// spi_io_expander_pkg : address map, command bit and FSM states (Rev 1.0)
// ==========================================================================
package spi_io_expander_pkg;

   localparam logic [6:0] OUT_BASE  = 7'h00;
   localparam logic [6:0] DIR_BASE  = 7'h10;
   localparam logic [6:0] IN_BASE   = 7'h20;
   localparam logic [6:0] MASK_BASE = 7'h30;
   localparam logic [6:0] STAT_BASE = 7'h40;

   localparam int CMD_READ_BIT = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   // Each register bank occupies one 16-address block.
   function automatic logic bank_hit(input logic [6:0] a, input logic [6:0] base);
      return a[6:4] == base[6:4];
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_io_expander_frontend.sv
`default_nettype none
// ==========================================================================
// spi_frontend : oversampled mode-0 SPI slave (sync, edges, shifters) Rev 1.0
// ==========================================================================
module spi_frontend
   import spi_io_expander_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ss,
   input  logic       sclk,
   input  logic       mosi,
   input  logic       load,
   input  logic [7:0] load_data,
   output logic       active,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       miso,
   output logic       miso_oe
);
   logic [SYNC_STAGES-1:0] sclk_pipe, ss_pipe, mosi_pipe;
   logic       s_sclk, s_ss, s_mosi;
   logic       sclk_d, ss_d, load_d;
   logic       rise, fall, ss_fall;
   logic [2:0] bit_cnt;
   logic [7:0] tx;

   assign s_sclk  = sclk_pipe[SYNC_STAGES-1];
   assign s_ss    = ss_pipe[SYNC_STAGES-1];
   assign s_mosi  = mosi_pipe[SYNC_STAGES-1];
   assign rise    = s_sclk & ~sclk_d;
   assign fall    = ~s_sclk & sclk_d;
   assign ss_fall = ss_d & ~s_ss;

   // ss chain resets low so a select held through reset never looks like a new frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_pipe  <= '0;
         ss_pipe    <= '0;
         mosi_pipe  <= '0;
         sclk_d     <= 1'b0;
         ss_d       <= 1'b0;
         load_d     <= 1'b0;
         active     <= 1'b0;
         byte_valid <= 1'b0;
         rx_byte    <= 8'h00;
         bit_cnt    <= 3'd0;
         tx         <= 8'h00;
         miso       <= 1'b0;
         miso_oe    <= 1'b0;
      end else begin
         sclk_pipe  <= {sclk_pipe[SYNC_STAGES-2:0], sclk};
         ss_pipe    <= {ss_pipe[SYNC_STAGES-2:0], ss};
         mosi_pipe  <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
         sclk_d     <= s_sclk;
         ss_d       <= s_ss;
         load_d     <= load;
         byte_valid <= 1'b0;
         miso_oe    <= active & ~s_ss;
         if (s_ss) begin
            active  <= 1'b0;
            bit_cnt <= 3'd0;
            tx      <= 8'h00;
            miso    <= 1'b0;
         end else begin
            if (ss_fall)
               active <= 1'b1;
            if (active && rise) begin
               rx_byte    <= {rx_byte[6:0], s_mosi};
               bit_cnt    <= bit_cnt + 3'd1;
               byte_valid <= (bit_cnt == 3'd7);
            end
            if (load)
               tx <= load_data;
            // Bit 7 goes out right after the load; the falling edge closing a byte is skipped.
            if (load_d)
               miso <= tx[7];
            else if (active && fall && (bit_cnt != 3'd0))
               miso <= tx[3'd7 - bit_cnt];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_io_expander.sv
`default_nettype none
// ==========================================================================
// spi_io_expander : SPI GPIO expander top; SPI_IO_EXPANDER_IRQ_EN adds IRQs
// Rev 1.0
// ==========================================================================
module spi_io_expander
   import spi_io_expander_pkg::*;
#(
   parameter int NUM_PORTS   = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ss,
   input  logic                   sclk,
   input  logic                   mosi,
   output logic                   miso,
   output logic                   miso_oe,
   input  logic [8*NUM_PORTS-1:0] gpio_in,
   output logic [8*NUM_PORTS-1:0] gpio_out,
   output logic [8*NUM_PORTS-1:0] gpio_oe,
   output logic                   irq
);
   localparam int W = 8 * NUM_PORTS;

   logic         active, byte_valid, load, rd, wr_en;
   logic [7:0]   rx_byte, load_data;
   logic [6:0]   addr, load_addr;
   state_t       state;
   logic [7:0]   out_r [NUM_PORTS];
   logic [7:0]   dir_r [NUM_PORTS];
   logic [W-1:0] in_pipe [SYNC_STAGES];
   logic [W-1:0] in_val;
`ifdef SPI_IO_EXPANDER_IRQ_EN
   logic [7:0]   mask_r [NUM_PORTS];
   logic [7:0]   stat_r [NUM_PORTS];
   logic [W-1:0] in_prev;
   logic         irq_r, stat_any;
`endif

   spi_frontend #(.SYNC_STAGES(SYNC_STAGES)) u_frontend (
      .clk        (clk),
      .rst        (rst),
      .ss         (ss),
      .sclk       (sclk),
      .mosi       (mosi),
      .load       (load),
      .load_data  (load_data),
      .active     (active),
      .byte_valid (byte_valid),
      .rx_byte    (rx_byte),
      .miso       (miso),
      .miso_oe    (miso_oe)
   );

   assign in_val    = in_pipe[SYNC_STAGES-1];
   assign load_addr = (state == ST_CMD) ? rx_byte[6:0] : addr + 7'd1;
   assign wr_en     = byte_valid && active && (state == ST_DATA) && !rd;
   assign load      = byte_valid && active &&
                      (((state == ST_CMD) && rx_byte[CMD_READ_BIT]) || ((state == ST_DATA) && rd));

   always_comb begin
      load_data = 8'h00;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (load_addr[3:0] == 4'(p)) begin
            if (bank_hit(load_addr, OUT_BASE))  load_data = out_r[p];
            if (bank_hit(load_addr, DIR_BASE))  load_data = dir_r[p];
            if (bank_hit(load_addr, IN_BASE))   load_data = in_val[8*p +: 8];
`ifdef SPI_IO_EXPANDER_IRQ_EN
            if (bank_hit(load_addr, MASK_BASE)) load_data = mask_r[p];
            if (bank_hit(load_addr, STAT_BASE)) load_data = stat_r[p];
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         addr  <= 7'h00;
         rd    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (active) state <= ST_CMD;
            ST_CMD: begin
               if (!active)
                  state <= ST_IDLE;
               else if (byte_valid) begin
                  state <= ST_DATA;
                  addr  <= rx_byte[6:0];
                  rd    <= rx_byte[CMD_READ_BIT];
               end
            end
            ST_DATA: begin
               if (!active)
                  state <= ST_IDLE;
               else if (byte_valid)
                  addr <= addr + 7'd1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            out_r[p] <= 8'h00;
            dir_r[p] <= 8'h00;
         end
         for (int s = 0; s < SYNC_STAGES; s++)
            in_pipe[s] <= '0;
         gpio_out <= '0;
         gpio_oe  <= '0;
      end else begin
         in_pipe[0] <= gpio_in;
         for (int s = 1; s < SYNC_STAGES; s++)
            in_pipe[s] <= in_pipe[s-1];
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (wr_en && (addr[3:0] == 4'(p))) begin
               if (bank_hit(addr, OUT_BASE)) out_r[p] <= rx_byte;
               if (bank_hit(addr, DIR_BASE)) dir_r[p] <= rx_byte;
            end
            gpio_out[8*p +: 8] <= out_r[p];
            gpio_oe[8*p +: 8]  <= dir_r[p];
         end
      end
   end

`ifdef SPI_IO_EXPANDER_IRQ_EN
   always_comb begin
      stat_any = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++)
         stat_any = stat_any | (|stat_r[p]);
   end

   // A change detected in the same clk as a W1C keeps the bit set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            mask_r[p] <= 8'h00;
            stat_r[p] <= 8'h00;
         end
         in_prev <= '0;
         irq_r   <= 1'b0;
      end else begin
         in_prev <= in_val;
         irq_r   <= stat_any;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (wr_en && (addr[3:0] == 4'(p)) && bank_hit(addr, MASK_BASE))
               mask_r[p] <= rx_byte;
            stat_r[p] <= (stat_r[p] & ~((wr_en && (addr[3:0] == 4'(p)) && bank_hit(addr, STAT_BASE))
                                        ? rx_byte : 8'h00))
                       | ((in_val[8*p +: 8] ^ in_prev[8*p +: 8]) & mask_r[p]);
         end
      end
   end

   assign irq = irq_r;
`else
   assign irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/spi_io_expander.md
# spi_io_expander

Parametrised SPI-controlled GPIO expander, successor to the fixed 8-bit expander top. A mode-0 SPI slave, oversampled by the system clock, gives register-addressed access to NUM_PORTS 8-bit GPIO ports. Each port has output, direction, synchronised input and optional change-interrupt registers. The block sits directly behind the chip pads: SPI on four pins, GPIO banks on the rest.

## Interface
- NUM_PORTS, 2, number of 8-bit GPIO ports (1..8)
- SYNC_STAGES, 2, synchroniser depth for sclk/ss/mosi and gpio_in (>=2)

- clk  in  1  system clock; must run at ≥4× sclk frequency
- rst  in  1  reset, asynchronous, active-high
- ss  in  1  SPI slave select, active-low
- sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
- mosi  in  1  SPI data in, MSB first
- miso  out  1  SPI data out, MSB first
- miso_oe  out  1  miso pad enable; high only while synchronised ss is low
- gpio_in  in  8*NUM_PORTS  pad inputs, asynchronous
- gpio_out  out  8*NUM_PORTS  OUT register contents
- gpio_oe  out  8*NUM_PORTS  DIR register contents (1 = drive)
- irq  out  1  level interrupt, OR of all status bits

## Operation
- Frame: ss falls → command byte → zero or more data bytes → ss rises.
- Command byte: bit7 = 1 read / 0 write; bits6:0 = start address.
- Address map, p = port index: 0x00+p OUT (RW), 0x10+p DIR (RW), 0x20+p IN (RO, synchronised gpio_in), 0x30+p IRQ_MASK (RW), 0x40+p IRQ_STATUS (W1C).
- Unmapped addresses and p ≥ NUM_PORTS read 0x00. Writes to them are ignored. Writes to IN are ignored.
- Address auto-increments after every data byte. It wraps 0x7F → 0x00.
- Write: each complete data byte commits to the current address.
- Read: the shift register is loaded with the current address value at each byte boundary. The first load happens at the end of the command byte. The command byte shifts out 0x00.
- FSM states:
  - IDLE → CMD on ss low.
  - CMD → DATA after 8 bits.
  - DATA → DATA per byte.
  - Any state → IDLE on ss high.
- Reset values: all registers 0; gpio_out 0, gpio_oe 0, miso 0, miso_oe 0, irq 0, FSM IDLE.

## Timing
- sclk, ss and mosi pass through SYNC_STAGES flops. The edge detector runs on synchronised sclk.
- mosi is sampled on the detected sclk rising edge.
- miso updates on the detected falling edge. The first bit is presented one clk after the byte-boundary load.
- Write commit: the register updates on the clk edge after the 8th rising edge is detected. gpio_out/gpio_oe change one clk later, as registered outputs.
- IN value = gpio_in delayed by SYNC_STAGES clks. A read captures this value at load time.
- ss rises mid-byte: the partial byte is discarded, the bit counter is cleared and the FSM returns to IDLE. Already committed bytes stay.
- Async rst mid-frame: everything returns to reset values immediately. The frame resumes only after the next ss falling edge.

## Configuration
- Macro: SPI_IO_EXPANDER_IRQ_EN.
- Defined:
  - IRQ_STATUS[p][b] sets when synced IN[p][b] differs from its previous-clk value and IRQ_MASK[p][b] = 1.
  - Writing 1 clears a status bit. Set and clear in the same clk → set wins.
  - irq = |status, registered.
- Undefined:
  - MASK/STATUS addresses are unmapped (read 0x00).
  - irq tied 0; no change-detect logic.

## Structure
- Package spi_io_expander_pkg holds:
  - the address base constants (OUT_BASE 0x00, DIR_BASE 0x10, IN_BASE 0x20, MASK_BASE 0x30, STAT_BASE 0x40);
  - CMD_READ_BIT = 7;
  - the FSM state enum.
- Sub-module spi_frontend handles synchronisers, edge detect, shift register, bit counter and byte_valid/load strobes.
- The top holds the FSM, address counter, register file and IRQ logic.

## Test plan
- Reset: assert rst mid-operation → all outputs 0, miso_oe 0, irq 0.
- Write burst: frame 0x00, 0xA5, 0x3C with NUM_PORTS=2 → gpio_out = 0x3CA5. Then frame 0x10, 0xFF → gpio_oe[7:0] = 0xFF.
- Read: gpio_in = 0x5A12, frame 0xA0 + 2 dummy bytes → miso bytes 0x00, 0x12, 0x5A.
- Boundaries:
  - Write 0x7F, 0x11, 0x22 → address 0x00 receives 0x22.
  - Read at 0x05 → 0x00.
  - ss rises after 4 bits of a data byte → no register change.
- IRQ (macro on): mask[0] = 0x01, toggle gpio_in[0] → irq high after SYNC_STAGES+2 clks. Write 0x01 to 0x40 → irq low. A simultaneous toggle keeps irq high.
